// File: rtl/obuf_accum.sv
// -----------------------------------------------------------------------------
// obuf_accum
//   Output-stationary accumulation buffer on the MAC array output path.
//   Collects LANES signed scalars of DW bits from the column stream, adds each
//   one to the matching lane of a previously loaded partial-sum word (or passes
//   it through), and emits the packed LANES*DW word through a one-entry
//   valid/ready output slot.
//
// Parameters
//   DW     bits per lane / scalar
//   LANES  lanes per packed word (>= 2)
//   SAT    1 = signed saturating add, 0 = two's-complement wrap
//
// Ports
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   CLR        synchronous abort of the partial word in progress
//   ACC        1 = add previous lane, 0 = pass IN_DATA through
//   PREV_LOAD  load PREV_DATA into the previous-word register
//   PREV_DATA  previous partial-sum word, lane k at [k*DW +: DW]
//   IN_VALID   input scalar valid
//   IN_READY   input accepted when IN_VALID && IN_READY
//   IN_DATA    signed scalar partial sum
//   OUT_VALID  packed word valid
//   OUT_READY  consumer accepts the word
//   OUT_DATA   packed word, lane k at [k*DW +: DW]
//   OVF        sticky overflow / saturation flag
//   OVF_CLR    clears OVF (a same-cycle set wins)
// -----------------------------------------------------------------------------
module obuf_accum #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int SAT   = 1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                CLR,
  input  logic                ACC,
  input  logic                PREV_LOAD,
  input  logic [LANES*DW-1:0] PREV_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [DW-1:0]       IN_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES*DW-1:0] OUT_DATA,
  output logic                OVF,
  input  logic                OVF_CLR
);

  localparam int            CW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LANES - 1);
  localparam logic [DW-1:0] POS_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN  = {1'b1, {(DW-1){1'b0}}};

  // Signed lane add. Returns {overflow, result}; overflow means both operands
  // share a sign that the wrapped sum does not. With SAT the result clamps
  // toward the operands' sign, otherwise the wrapped sum is kept.
  function automatic logic [DW:0] add_lane(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] sum_v;
    logic [DW-1:0] res_v;
    logic          ovf_v;
    sum_v = a + b;
    ovf_v = (a[DW-1] == b[DW-1]) && (sum_v[DW-1] != a[DW-1]);
    if (ovf_v && (SAT != 0)) begin
      res_v = a[DW-1] ? NEG_MIN : POS_MAX;
    end else begin
      res_v = sum_v;
    end
    return {ovf_v, res_v};
  endfunction

  logic [CW-1:0]       cnt_r;
  logic [DW-1:0]       prev_r  [LANES];
  logic [DW-1:0]       local_r [LANES];
  logic                out_valid_r;
  logic [LANES*DW-1:0] out_data_r;
  logic                ovf_r;

  logic                is_last_s;
  logic                in_ready_s;
  logic                xfer_s;
  logic [DW-1:0]       prev_lane_s;
  logic [DW:0]         sum_pkt_s;
  logic [DW-1:0]       seg_s;
  logic                seg_ovf_s;
  logic [LANES*DW-1:0] final_word_s;

  assign is_last_s   = (cnt_r == LAST_IDX);
  // Only the final lane can stall: it needs the output slot to be free or
  // draining in this very cycle.
  assign in_ready_s  = !(is_last_s && out_valid_r && !OUT_READY);
  // A transfer coinciding with CLR is dropped entirely.
  assign xfer_s      = IN_VALID && in_ready_s && !CLR;
  assign prev_lane_s = prev_r[cnt_r];
  assign sum_pkt_s   = add_lane(prev_lane_s, IN_DATA);

  // Per-lane result: accumulate or pass through, plus its overflow indication.
  always_comb begin
    seg_s     = IN_DATA;
    seg_ovf_s = 1'b0;
    if (ACC) begin
      seg_s     = sum_pkt_s[DW-1:0];
      seg_ovf_s = sum_pkt_s[DW];
    end else begin
      seg_s     = IN_DATA;
      seg_ovf_s = 1'b0;
    end
  end

  // Completed word: stored lanes 0..LANES-2 plus the lane being accepted now.
  always_comb begin
    final_word_s = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      final_word_s[k*DW +: DW] = local_r[k];
    end
    final_word_s[(LANES-1)*DW +: DW] = seg_s;
  end

  // Lane counter: CLR aborts the word, otherwise advance on each transfer.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r <= '0;
    end else if (CLR) begin
      cnt_r <= '0;
    end else if (xfer_s) begin
      if (is_last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Local lane storage; lanes are never cleared, each is rewritten before use.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < LANES; k++) begin
        local_r[k] <= '0;
      end
    end else if (xfer_s) begin
      local_r[cnt_r] <= seg_s;
    end
  end

  // Previous-word register; a same-cycle transfer still sees the old value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < LANES; k++) begin
        prev_r[k] <= '0;
      end
    end else if (PREV_LOAD) begin
      for (int k = 0; k < LANES; k++) begin
        prev_r[k] <= PREV_DATA[k*DW +: DW];
      end
    end
  end

  // One-entry output slot: a new final lane refills it even while draining.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (xfer_s && is_last_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= final_word_s;
    end else if (OUT_READY) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky overflow flag; a set in the same cycle as OVF_CLR wins.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovf_r <= 1'b0;
    end else if (xfer_s && seg_ovf_s) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_r;
  assign OUT_DATA  = out_data_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_obuf_accum.sv
// -----------------------------------------------------------------------------
// tb_obuf_accum
//   Drives a saturating and a wrapping instance of obuf_accum with the same
//   stimulus and compares both against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_obuf_accum;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int W     = DW * LANES;
  localparam int MAXV  = (1 << (DW - 1)) - 1;
  localparam int MINV  = -(1 << (DW - 1));
  localparam int MASK  = (1 << DW) - 1;

  logic         CLK = 1'b0;
  logic         RSTN, CLR, ACC, PREV_LOAD, IN_VALID, OUT_READY, OVF_CLR;
  logic [W-1:0] PREV_DATA;
  logic [DW-1:0] IN_DATA;
  logic         IN_READY, OUT_VALID, OVF;
  logic [W-1:0] OUT_DATA;
  logic         IN_READY_W, OUT_VALID_W, OVF_W;
  logic [W-1:0] OUT_DATA_W;

  always #5 CLK = ~CLK;

  obuf_accum #(.DW(DW), .LANES(LANES), .SAT(1)) dut_sat (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .ACC(ACC), .PREV_LOAD(PREV_LOAD),
    .PREV_DATA(PREV_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  obuf_accum #(.DW(DW), .LANES(LANES), .SAT(0)) dut_wrap (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .ACC(ACC), .PREV_LOAD(PREV_LOAD),
    .PREV_DATA(PREV_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY_W),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID_W), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA_W), .OVF(OVF_W), .OVF_CLR(OVF_CLR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes held as plain integers, sums done in int.
  int           m_prev  [LANES];
  int           m_loc_s [LANES];
  int           m_loc_w [LANES];
  int           m_cnt;
  bit           m_vld;
  bit           m_ovf;
  logic [W-1:0] m_out_s;
  logic [W-1:0] m_out_w;

  function automatic int sx(input int v);
    return (v > MAXV) ? v - (1 << DW) : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) begin
      m_prev[k] = 0; m_loc_s[k] = 0; m_loc_w[k] = 0;
    end
    m_cnt = 0; m_vld = 1'b0; m_ovf = 1'b0;
    m_out_s = '0; m_out_w = '0;
  endtask

  function automatic bit model_ready();
    return !((m_cnt == LANES - 1) && m_vld && !OUT_READY);
  endfunction

  task automatic model_update(input bit rdy);
    int s, seg_sat, seg_wrap;
    bit ov, xfer, fin;
    ov = 1'b0; fin = 1'b0;
    xfer = IN_VALID && rdy && !CLR;
    if (xfer) begin
      if (ACC) begin
        s        = sx(m_prev[m_cnt]) + sx(int'(IN_DATA));
        ov       = (s > MAXV) || (s < MINV);
        seg_wrap = s & MASK;
        seg_sat  = ((s > MAXV) ? MAXV : (s < MINV) ? MINV : s) & MASK;
      end else begin
        seg_wrap = int'(IN_DATA);
        seg_sat  = int'(IN_DATA);
      end
      m_loc_s[m_cnt] = seg_sat;
      m_loc_w[m_cnt] = seg_wrap;
      if (m_cnt == LANES - 1) begin
        fin = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          m_out_s[k*DW +: DW] = DW'(m_loc_s[k]);
          m_out_w[k*DW +: DW] = DW'(m_loc_w[k]);
        end
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (xfer && ov) m_ovf = 1'b1;
    else if (OVF_CLR) m_ovf = 1'b0;
    if (fin) m_vld = 1'b1;
    else if (OUT_READY) m_vld = 1'b0;
    if (CLR) m_cnt = 0;
    if (PREV_LOAD) begin
      for (int k = 0; k < LANES; k++) m_prev[k] = int'(PREV_DATA[k*DW +: DW]);
    end
  endtask

  // One clock: check IN_READY ahead of the edge, advance model, check outputs.
  task automatic step();
    bit rdy;
    #1;
    rdy = model_ready();
    check_eq("in_ready", W'(IN_READY), W'(rdy));
    check_eq("in_ready_w", W'(IN_READY_W), W'(rdy));
    @(posedge CLK);
    model_update(rdy);
    #1;
    check_eq("out_valid", W'(OUT_VALID), W'(m_vld));
    check_eq("out_valid_w", W'(OUT_VALID_W), W'(m_vld));
    check_eq("out_data_sat", OUT_DATA, m_out_s);
    check_eq("out_data_wrap", OUT_DATA_W, m_out_w);
    check_eq("ovf", W'(OVF), W'(m_ovf));
    check_eq("ovf_w", W'(OVF_W), W'(m_ovf));
  endtask

  task automatic send(input logic [DW-1:0] d, input logic acc);
    IN_VALID = 1'b1; IN_DATA = d; ACC = acc;
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic load_prev(input logic [W-1:0] word);
    PREV_LOAD = 1'b1; PREV_DATA = word;
    step();
    PREV_LOAD = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pick [4];
    pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'h0001; pick[3] = 16'hFFFF;

    RSTN = 1'b0; CLR = 1'b0; ACC = 1'b0; PREV_LOAD = 1'b0; IN_VALID = 1'b0;
    OUT_READY = 1'b1; OVF_CLR = 1'b0; PREV_DATA = '0; IN_DATA = '0;
    model_reset();
    #12;
    check_eq("rst_out_valid", W'(OUT_VALID), 64'h0);
    check_eq("rst_out_data", OUT_DATA, 64'h0);
    check_eq("rst_ovf", W'(OVF), 64'h0);
    check_eq("rst_in_ready", W'(IN_READY), 64'h1);
    RSTN = 1'b1;
    step();

    // Accumulate onto {10,20,30,40}
    load_prev({16'd40, 16'd30, 16'd20, 16'd10});
    send(16'd1, 1'b1); send(16'd2, 1'b1); send(16'd3, 1'b1); send(16'd4, 1'b1);
    check_eq("acc_valid", W'(OUT_VALID), 64'h1);
    check_eq("acc_word", OUT_DATA, 64'h002C_0021_0016_000B);
    check_eq("acc_ovf", W'(OVF), 64'h0);
    step();
    check_eq("acc_pulse", W'(OUT_VALID), 64'h0);

    // Pass-through ignores prev
    send(16'hAAAA, 1'b0); send(16'hBBBB, 1'b0); send(16'hCCCC, 1'b0); send(16'hDDDD, 1'b0);
    check_eq("pass_word", OUT_DATA, 64'hDDDD_CCCC_BBBB_AAAA);
    check_eq("pass_word_w", OUT_DATA_W, 64'hDDDD_CCCC_BBBB_AAAA);

    // Saturation vs wrap
    load_prev(64'h0000_0000_0000_7FF0);
    send(16'h0020, 1'b1);
    check_eq("sat_ovf", W'(OVF), 64'h1);
    check_eq("sat_ovf_w", W'(OVF_W), 64'h1);
    send(16'h0000, 1'b1); send(16'h0000, 1'b1); send(16'h0000, 1'b1);
    check_eq("sat_word", OUT_DATA, 64'h0000_0000_0000_7FFF);
    check_eq("wrap_word", OUT_DATA_W, 64'h0000_0000_0000_8010);
    OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
    check_eq("ovf_clr", W'(OVF), 64'h0);
    check_eq("ovf_clr_w", W'(OVF_W), 64'h0);

    // Back-pressure
    OUT_READY = 1'b0;
    send(16'h1111, 1'b0); send(16'h2222, 1'b0); send(16'h3333, 1'b0); send(16'h4444, 1'b0);
    send(16'h5555, 1'b0); send(16'h6666, 1'b0); send(16'h7777, 1'b0);
    IN_VALID = 1'b1; IN_DATA = 16'h8888; ACC = 1'b0;
    #1;
    check_eq("bp_stall", W'(IN_READY), 64'h0);
    step(); step();
    check_eq("bp_hold_valid", W'(OUT_VALID), 64'h1);
    check_eq("bp_hold_word", OUT_DATA, 64'h4444_3333_2222_1111);
    OUT_READY = 1'b1;
    #1;
    check_eq("bp_release", W'(IN_READY), 64'h1);
    step();
    IN_VALID = 1'b0;
    check_eq("bp_refill_valid", W'(OUT_VALID), 64'h1);
    check_eq("bp_refill_word", OUT_DATA, 64'h8888_7777_6666_5555);
    step();

    // CLR with a pending word; the dropped transfer would have overflowed
    load_prev(64'h0000_7FFF_0000_0000);
    OUT_READY = 1'b0;
    send(16'h0101, 1'b0); send(16'h0202, 1'b0); send(16'h0303, 1'b0); send(16'h0404, 1'b0);
    send(16'h0A0A, 1'b0); send(16'h0B0B, 1'b0);
    CLR = 1'b1; send(16'h7FFF, 1'b1); CLR = 1'b0;
    check_eq("clr_ovf", W'(OVF), 64'h0);
    send(16'h1234, 1'b0); send(16'h2345, 1'b0); send(16'h3456, 1'b0);
    check_eq("clr_pending", OUT_DATA, 64'h0404_0303_0202_0101);
    OUT_READY = 1'b1;
    send(16'h4567, 1'b0);
    check_eq("clr_word", OUT_DATA, 64'h4567_3456_2345_1234);
    step();
    check_eq("clr_single", W'(OUT_VALID), 64'h0);

    // Async reset mid-word with a pending word and OVF set
    OUT_READY = 1'b0;
    send(16'h0001, 1'b1); send(16'h0002, 1'b1); send(16'h0001, 1'b1); send(16'h0004, 1'b1);
    send(16'h0009, 1'b0); send(16'h0009, 1'b0);
    check_eq("ar_pre_ovf", W'(OVF), 64'h1);
    #3; RSTN = 1'b0; #1;
    check_eq("ar_valid", W'(OUT_VALID), 64'h0);
    check_eq("ar_data", OUT_DATA, 64'h0);
    check_eq("ar_ovf", W'(OVF), 64'h0);
    check_eq("ar_ready", W'(IN_READY), 64'h1);
    model_reset();
    @(negedge CLK); RSTN = 1'b1; OUT_READY = 1'b1;
    send(16'd5, 1'b1); send(16'd6, 1'b1); send(16'd7, 1'b1); send(16'd8, 1'b1);
    check_eq("ar_word", OUT_DATA, 64'h0008_0007_0006_0005);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      IN_VALID  = ($urandom_range(3) != 0);
      ACC       = $urandom_range(1);
      CLR       = ($urandom_range(15) == 0);
      PREV_LOAD = ($urandom_range(7) == 0);
      OVF_CLR   = ($urandom_range(7) == 0);
      OUT_READY = $urandom_range(1);
      for (int k = 0; k < LANES; k++) begin
        PREV_DATA[k*DW +: DW] = ($urandom_range(1) != 0) ? pick[$urandom_range(3)]
                                                         : DW'($urandom());
      end
      IN_DATA = ($urandom_range(3) == 0) ? pick[$urandom_range(3)] : DW'($urandom());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obuf_accum.md
Name: obuf_accum

Overview:
- Parametrised output-stationary accumulation buffer for the MAC array output path.
- Collects LANES scalar partial sums of DW bits from the array column stream.
- Adds each scalar to the matching lane of a previously loaded partial-sum word.
- Packs the results into one LANES*DW word, which leaves through a valid/ready handshake to the output-memory write FSM.
- Generalises the fixed 4x16-bit packer: configurable width and lane count, pass-through vs accumulate mode, signed saturation, overflow flag, output back-pressure.

Parameters:
- DW, 16, bits per lane/scalar.
- LANES, 4, lanes per packed word; must be >= 2.
- SAT, 1, 1 = signed saturating add; 0 = two's-complement wrap.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous abort of the partial word in progress.
- ACC  in  1  1 = add PREV lane; 0 = pass IN_DATA through unchanged.
- PREV_LOAD  in  1  load PREV_DATA into the previous-word register.
- PREV_DATA  in  LANES*DW  previous partial-sum word.
- IN_VALID  in  1  input scalar valid.
- IN_READY  out  1  input accepted when IN_VALID && IN_READY.
- IN_DATA  in  DW  signed scalar partial sum.
- OUT_VALID  out  1  packed word valid.
- OUT_READY  in  1  consumer accepts the word.
- OUT_DATA  out  LANES*DW  packed word; lane k at [k*DW +: DW].
- OVF  out  1  sticky overflow/saturation flag.
- OVF_CLR  in  1  clears OVF.

Behaviour:
- Reset (RSTN low, async): OUT_VALID=0, OUT_DATA=0, OVF=0, lane counter cnt=0, local word=0, prev word=0. IN_READY is 1 after reset.
- Lane order:
  - The k-th accepted scalar of a word (k=0 first) is combined with prev lane k.
  - The result is written to local lane k.
  - cnt counts 0..LANES-1, width clog2(LANES).
- Per-lane result:
  - ACC=0: seg = IN_DATA.
  - ACC=1: seg = prev[k] + IN_DATA, both signed.
  - Signed overflow (operand signs equal, result sign differs) sets OVF in both SAT modes.
  - SAT=1 clamps to 2^(DW-1)-1 or -2^(DW-1).
  - SAT=0 keeps the wrapped sum.
- ACC is sampled per transfer, so mixed-mode words are legal.
- Transfer at cnt<LANES-1: store seg, cnt++.
- Transfer at cnt==LANES-1:
  - OUT_DATA <= local word with lane LANES-1 = seg.
  - OUT_VALID <= 1, cnt <= 0.
  - Latency: OUT_VALID rises the cycle after the last lane is accepted.
- Local lanes are not cleared between words. Every lane is overwritten before it is emitted.
- Output slot holds one entry:
  - OUT_VALID and OUT_DATA stay stable until OUT_VALID && OUT_READY.
  - On that handshake OUT_VALID <= 0, unless a new final lane is accepted in the same cycle. In that case OUT_VALID stays 1 and OUT_DATA takes the new word.
- IN_READY = !(cnt==LANES-1 && OUT_VALID && !OUT_READY). It is combinational from OUT_READY. Earlier lanes are never stalled.
- PREV_LOAD:
  - Writes prev at the clock edge.
  - A transfer in the same cycle uses the old prev value.
  - Loading mid-word is legal; the remaining lanes use the new value.
- CLR:
  - cnt <= 0.
  - A simultaneous input transfer is dropped and does not affect OVF.
  - A pending OUT_VALID word is unaffected.
  - prev is unaffected.
- OVF_CLR clears OVF. A set in the same cycle wins, so OVF stays 1.
- IN_VALID low holds all state; there is no timeout.

Test Plan:
- DW=16, LANES=4, ACC=1, prev lanes {0:10, 1:20, 2:30, 3:40}, inputs 1,2,3,4 back-to-back, OUT_READY=1 -> one OUT_VALID pulse the cycle after the 4th input, OUT_DATA=0x002C_0021_0016_000B (lane 0 in the low bits), OVF=0.
- ACC=0, inputs 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> OUT_DATA=0xDDDD_CCCC_BBBB_AAAA regardless of prev contents.
- Saturation:
  - SAT=1, prev lane 0=0x7FF0, ACC=1, input 0x0020 -> lane 0=0x7FFF, OVF=1.
  - SAT=0 build, same stimulus -> lane 0=0x8010, OVF=1.
  - OVF_CLR pulse then clears OVF.
- Back-pressure:
  - OUT_READY=0 with a word pending, then 4 more inputs -> lanes 0-2 accepted, IN_READY=0 at lane 3, first word stable.
  - OUT_READY=1 for one cycle -> first word handshakes; lane 3 is accepted in the same cycle; OUT_VALID stays 1 with the second word.
- CLR after 2 lanes, then 4 fresh inputs -> exactly one output word, built only from the fresh inputs; pending output untouched.
- RSTN asserted asynchronously mid-word (cnt=2, OUT_VALID=1) -> all outputs 0 immediately; after release the next 4 inputs produce a word with prev=0.
